hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage MIPS pipeline: shadow E/M/W
// slots, D-stage stall, D/E forwarding selects and the mult/div busy counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] rs_use,
  input  logic [1:0] rt_use,
  input  logic [4:0] wreg_d,
  input  logic [1:0] tnew_d,
  input  logic [1:0] src_d,
  input  logic [1:0] md_d,
  output logic       stall,
  output logic [1:0] trans_d1,
  output logic [1:0] trans_d2,
  output logic [1:0] trans_e1,
  output logic [1:0] trans_e2,
  output logic       md_start,
  output logic       md_busy
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
    logic [1:0] tnew;
    logic [1:0] src;
  } slot_t;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_PC8 = 2'd2;

  slot_t      e_q, m_q, w_q;
  logic [1:0] e_md_q;
  logic [3:0] busy_q, busy_d;

  // Register 0 is hardwired, so it never forms a dependency.
  function automatic logic hit(input logic [4:0] r, input logic [4:0] w);
    hit = (r != 5'd0) && (r == w);
  endfunction

  function automatic logic dep(input logic [4:0] r, input logic [1:0] use_t,
                               input slot_t e, input slot_t m);
    dep = (use_t != 2'd3) &&
          ((hit(r, e.wreg) && (e.tnew > use_t)) || (hit(r, m.wreg) && (m.tnew > use_t)));
  endfunction

  function automatic logic [1:0] fwd_m(input logic [4:0] r, input slot_t m);
    fwd_m = 2'd0;
    if (hit(r, m.wreg) && (m.tnew == 2'd0)) begin
      if (m.src == SRC_PC8)      fwd_m = 2'd2;
      else if (m.src == SRC_ALU) fwd_m = 2'd1;
    end
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] r, input slot_t m, input slot_t w);
    fwd_e = fwd_m(r, m);
    if ((fwd_e == 2'd0) && hit(r, w.wreg)) fwd_e = 2'd3;
  endfunction

  function automatic slot_t advance(input slot_t s);
    advance = s;
    if (s.tnew != 2'd0) advance.tnew = s.tnew - 2'd1;
  endfunction

  assign md_start = (e_md_q == 2'd1) || (e_md_q == 2'd2);
  assign md_busy  = (busy_q != 4'd0);

  assign stall = dep(rs_d, rs_use, e_q, m_q) || dep(rt_d, rt_use, e_q, m_q) ||
                 ((md_d != 2'd0) && (md_busy || md_start));

  assign trans_d1 = fwd_m(rs_d, m_q);
  assign trans_d2 = fwd_m(rt_d, m_q);
  assign trans_e1 = fwd_e(e_q.rs, m_q, w_q);
  assign trans_e2 = fwd_e(e_q.rt, m_q, w_q);

  always_comb begin
    busy_d = busy_q;
    if (md_start)             busy_d = (e_md_q == 2'd1) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    else if (busy_q != 4'd0)  busy_d = busy_q - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      e_md_q <= 2'd0;
      busy_q <= 4'd0;
    end else begin
      w_q    <= advance(m_q);
      m_q    <= advance(e_q);
      busy_q <= busy_d;
      // A stalled D instruction stays in F/D; E gets a bubble instead.
      if (stall) begin
        e_q    <= '0;
        e_md_q <= 2'd0;
      end else begin
        e_q    <= '{rs: rs_d, rt: rt_d, wreg: wreg_d, tnew: tnew_d, src: src_d};
        e_md_q <= md_d;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random instruction streams,
// checked per cycle against an instruction-age reference model.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_d = '0, rt_d = '0, wreg_d = '0;
  logic [1:0] rs_use = 2'd3, rt_use = 2'd3, tnew_d = '0, src_d = '0, md_d = '0;
  logic       stall, md_start, md_busy;
  logic [1:0] trans_d1, trans_d2, trans_e1, trans_e2;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rs_use(rs_use), .rt_use(rt_use),
    .wreg_d(wreg_d), .tnew_d(tnew_d), .src_d(src_d), .md_d(md_d), .stall(stall),
    .trans_d1(trans_d1), .trans_d2(trans_d2), .trans_e1(trans_e1), .trans_e2(trans_e2),
    .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, wreg;
    logic [1:0] tnew, src, md;
    int         enter;
  } ins_t;

  ins_t        hist[$];
  logic [10:0] exp_q[$];
  int          cyc = 0;
  int          ms_cyc = -1000;
  int          ms_n = 0;
  int          checks = 0;
  int          errors = 0;
  logic        driver_done = 1'b0;

  // Reference model: an instruction that entered E at cycle t sits in stage
  // (cyc - t) with Tnew reduced by its age; the mult/div unit is busy for the
  // N cycles following the cycle its start op sat in E.
  task automatic model_eval(output logic stl);
    ins_t s[3];
    logic p[3];
    logic [4:0] w[3];
    int tn[3];
    logic busy, e_start, mds;
    logic [1:0] td1, td2, te1, te2;
    for (int k = 0; k < 3; k++) p[k] = 1'b0;
    foreach (hist[i]) begin
      int k;
      k = cyc - hist[i].enter;
      if (k >= 0 && k <= 2) begin s[k] = hist[i]; p[k] = 1'b1; end
    end
    for (int k = 0; k < 3; k++) begin
      w[k]  = p[k] ? s[k].wreg : 5'd0;
      tn[k] = (p[k] && int'(s[k].tnew) > k) ? int'(s[k].tnew) - k : 0;
    end
    busy    = (cyc > ms_cyc) && (cyc <= ms_cyc + ms_n);
    e_start = p[0] && (s[0].md == 2'd1 || s[0].md == 2'd2);
    mds     = (md_d != 0) && (busy || e_start);
    stl = mds || need(rs_d, rs_use, w[0], tn[0], w[1], tn[1])
              || need(rt_d, rt_use, w[0], tn[0], w[1], tn[1]);
    td1 = dfwd(rs_d, w[1], tn[1], p[1] ? s[1].src : 2'd0);
    td2 = dfwd(rt_d, w[1], tn[1], p[1] ? s[1].src : 2'd0);
    te1 = p[0] ? efwd(s[0].rs, w[1], tn[1], p[1] ? s[1].src : 2'd0, w[2]) : 2'd0;
    te2 = p[0] ? efwd(s[0].rt, w[1], tn[1], p[1] ? s[1].src : 2'd0, w[2]) : 2'd0;
    exp_q.push_back({stl, td1, td2, te1, te2, e_start, busy});
    if (e_start) begin
      ms_cyc = cyc;
      ms_n   = (s[0].md == 2'd1) ? MULT_N : DIV_N;
    end
    if (!stl) hist.push_back('{rs_d, rt_d, wreg_d, tnew_d, src_d, md_d, cyc + 1});
    while (hist.size() > 0 && hist[0].enter < cyc - 2) void'(hist.pop_front());
  endtask

  function automatic logic need(input logic [4:0] r, input logic [1:0] u,
                                input logic [4:0] we, input int te,
                                input logic [4:0] wm, input int tm);
    need = (r != 0) && (u != 3) && ((we == r && te > int'(u)) || (wm == r && tm > int'(u)));
  endfunction

  function automatic logic [1:0] dfwd(input logic [4:0] r, input logic [4:0] wm,
                                      input int tm, input logic [1:0] sm);
    dfwd = 2'd0;
    if (r != 0 && wm == r && tm == 0) dfwd = (sm == 2) ? 2'd2 : (sm == 0) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] efwd(input logic [4:0] r, input logic [4:0] wm,
                                      input int tm, input logic [1:0] sm,
                                      input logic [4:0] ww);
    efwd = dfwd(r, wm, tm, sm);
    if (efwd == 0 && r != 0 && ww == r) efwd = 2'd3;
  endfunction

  task automatic drive_cycle(input logic [4:0] rs, input logic [4:0] rt,
                             input logic [1:0] rsu, input logic [1:0] rtu,
                             input logic [4:0] wr, input logic [1:0] tn,
                             input logic [1:0] src, input logic [1:0] md,
                             output logic stl);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    rs_d = rs; rt_d = rt; rs_use = rsu; rt_use = rtu;
    wreg_d = wr; tnew_d = tn; src_d = src; md_d = md;
    model_eval(stl);
  endtask

  // Holds the D instruction until the model says it leaves D.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rsu, input logic [1:0] rtu,
                       input logic [4:0] wr, input logic [1:0] tn,
                       input logic [1:0] src, input logic [1:0] md);
    logic stl;
    int n;
    n = 0;
    do begin
      drive_cycle(rs, rt, rsu, rtu, wr, tn, src, md, stl);
      n++;
    end while (stl && n < 30);
    if (stl) begin
      $display("FAIL issue_bound: instruction still stalled after %0d cycles, limit 30", n);
      errors++;
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 3, 3, 0, 1, 0, 0);
  endtask

  // Reset is raised mid-cycle, so outputs must clear before any clock edge.
  task automatic reset_cycle();
    @(posedge clk);
    cyc++;
    #1;
    rs_d = 5'($urandom_range(0, 7)); rt_d = 5'($urandom_range(0, 7));
    rs_use = 2'($urandom_range(0, 3)); rt_use = 2'($urandom_range(0, 3));
    wreg_d = 5'($urandom_range(0, 7)); tnew_d = 2'($urandom_range(1, 2));
    src_d = 2'($urandom_range(0, 2)); md_d = 2'($urandom_range(0, 3));
    #1;
    reset = 1'b1;
    hist.delete();
    ms_cyc = -1000;
    exp_q.push_back(11'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e, a;
      e = exp_q.pop_front();
      a = {stall, trans_d1, trans_d2, trans_e1, trans_e2, md_start, md_busy};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs @%0d: got stall/td1/td2/te1/te2/start/busy=%b/%0d/%0d/%0d/%0d/%b/%b required %b/%0d/%0d/%0d/%0d/%b/%b",
                 cyc, a[10], a[9:8], a[7:6], a[5:4], a[3:2], a[1], a[0],
                 e[10], e[9:8], e[7:6], e[5:4], e[3:2], e[1], e[0]);
      end
    end
  end

  initial begin
    reset_cycle();
    reset_cycle();
    nop(2);
    // load-use: lw $8 then beq $8
    issue(29, 0, 1, 3, 8, 2, 1, 0);
    issue(8, 9, 0, 0, 0, 1, 0, 0);
    nop(3);
    // ALU forward to E, then W forward
    issue(1, 2, 1, 1, 9, 1, 0, 0);
    issue(3, 9, 1, 1, 10, 1, 0, 0);
    issue(4, 9, 1, 1, 11, 1, 0, 0);
    nop(3);
    // jal then jr $31
    issue(0, 0, 3, 3, 31, 1, 2, 0);
    issue(31, 0, 0, 3, 0, 1, 0, 0);
    nop(3);
    // register 0 never matches
    issue(5, 0, 1, 3, 0, 2, 1, 0);
    issue(0, 0, 0, 0, 0, 1, 0, 0);
    nop(3);
    // mult then mfhi, div then mflo
    issue(6, 7, 1, 1, 0, 1, 0, 1);
    issue(0, 0, 3, 3, 12, 1, 0, 3);
    nop(2);
    issue(6, 7, 1, 1, 0, 1, 0, 2);
    issue(0, 0, 3, 3, 13, 1, 0, 3);
    nop(2);
    // reset while the divider counts down with a load in M
    issue(6, 7, 1, 1, 0, 1, 0, 2);
    nop(2);
    issue(29, 0, 1, 3, 14, 2, 1, 0);
    nop(1);
    reset_cycle();
    nop(2);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0) reset_cycle();
      else issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 2'($urandom_range(1, 2)),
                 2'($urandom_range(0, 2)),
                 ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
    end
    driver_done = 1'b1;
  end

  initial begin
    wait (driver_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
